// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: Uop types shared by the writeback stage (regs, values, flags, exceptions, memory-stage uop, FSM states)
package Uop;
  localparam int SQ_W = 4;
  typedef logic [4:0] reg_t;
  typedef logic [31:0] val_t;
  typedef logic [3:0] flags_t;
  typedef enum logic [3:0] {EX_NONE, EX_ILLEGAL, EX_MEM_ALIGN, EX_MEM_FAULT, EX_ECALL} ex_t;
  typedef enum logic {WB_RUN, WB_SQUASH} wb_state_t;
  typedef struct packed {
    ex_t         ex;
    logic        exValid;
    reg_t        rd;
    val_t        rdVal;
    logic        rdWrite;
    logic        flagsValid;
    flags_t      flags;
    logic        memNack;
    logic [31:0] pc;
  } memory_t;
endpackage

// File: rtl/pipeline_if.sv
// pipeline_if: valid/stall handshake between pipeline stages
interface pipeline_if;
  logic valid;
  logic stall;
  modport Upstream(input valid, output stall);
  modport Downstream(output valid, input stall);
endinterface

// File: rtl/writeback_stage_squash_timer.sv
// squash_timer: loadable down-counter that stops at zero; done is high while the count is zero
// Ports: clk, rst (sync, active-high), load/val (load value), done
module squash_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= val;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign done = cnt_q == '0;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: commits memory-stage uops to RF/flags, turns exceptions and NACKs into flush+redirect, squashes the wrong path
// Ports: clk, rst (sync, active-high), u (valid in, stall out tied 0), uopIn, trapVector;
//   rfWe/rfWaddr/rfWdata, flagsWe/flagsOut (combinational commit), redirValid/redirPc/flush (registered pulse),
//   epc/cause (last trap), instret (retired count, only when WB_RETIRE_CNT_EN is defined).
module writeback_stage
  import Uop::*;
#(
  parameter int SQUASH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  pipeline_if.Upstream u,
  input  memory_t     uopIn,
  input  logic [31:0] trapVector,
  output logic        rfWe,
  output reg_t        rfWaddr,
  output val_t        rfWdata,
  output logic        flagsWe,
  output flags_t      flagsOut,
  output logic        redirValid,
  output logic [31:0] redirPc,
  output logic        flush,
  output logic [31:0] epc,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0] instret,
`endif
  output ex_t         cause
);
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(SQUASH_CYCLES - 1);
  wb_state_t   state_q, state_d;
  logic        redir_q;
  logic [31:0] redir_pc_q, epc_q;
  ex_t         cause_q;
  logic        live, take_ex, take_nack, fault, commit, done;
  assign u.stall   = 1'b0;
  assign live      = u.valid && state_q == WB_RUN && !rst;
  // exception wins over NACK: a faulting uop never reached the cache
  assign take_ex   = live && uopIn.exValid;
  assign take_nack = live && !uopIn.exValid && uopIn.memNack;
  assign fault     = take_ex || take_nack;
  assign commit    = live && !fault;
  assign rfWe      = commit && uopIn.rdWrite && uopIn.rd != '0;
  assign rfWaddr   = uopIn.rd;
  assign rfWdata   = uopIn.rdVal;
  assign flagsWe   = commit && uopIn.flagsValid;
  assign flagsOut  = uopIn.flags;
  assign redirValid = redir_q;
  assign flush      = redir_q;
  assign redirPc    = redir_pc_q;
  assign epc        = epc_q;
  assign cause      = cause_q;
  squash_timer #(.W(SQ_W)) u_timer (.clk(clk), .rst(rst), .load(fault), .val(SQ_INIT), .done(done));
  always_comb begin
    state_d = state_q;
    if (state_q == WB_RUN) state_d = fault ? WB_SQUASH : WB_RUN;
    else state_d = done ? WB_RUN : WB_SQUASH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WB_RUN;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      epc_q      <= '0;
      cause_q    <= EX_NONE;
    end else begin
      state_q    <= state_d;
      redir_q    <= fault;
      redir_pc_q <= take_ex ? trapVector : take_nack ? uopIn.pc : redir_pc_q;
      epc_q      <= take_ex ? uopIn.pc : epc_q;
      cause_q    <= take_ex ? uopIn.ex : cause_q;
    end
  end
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q;
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else if (commit) instret_q <= instret_q + 64'd1;
  end
  assign instret = instret_q;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage (SQUASH_CYCLES=3 and =1 instances)
module tb_writeback_stage;
  import Uop::*;
  logic        clk = 1'b0;
  logic        rst;
  memory_t     uop;
  logic [31:0] tv;
  int          n_chk = 0, n_fail = 0;
  pipeline_if  u0();
  pipeline_if  u1();
  logic        rf_we0, rf_we1, fl_we0, fl_we1, rv0, rv1, fl0, fl1;
  reg_t        rf_wa0, rf_wa1;
  val_t        rf_wd0, rf_wd1;
  flags_t      fo0, fo1;
  logic [31:0] rpc0, rpc1, epc0, epc1;
  ex_t         cause0, cause1;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] ir0, ir1;
`endif
  always #5 clk = ~clk;
  writeback_stage #(.SQUASH_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .u(u0), .uopIn(uop), .trapVector(tv),
    .rfWe(rf_we0), .rfWaddr(rf_wa0), .rfWdata(rf_wd0), .flagsWe(fl_we0), .flagsOut(fo0),
    .redirValid(rv0), .redirPc(rpc0), .flush(fl0), .epc(epc0),
`ifdef WB_RETIRE_CNT_EN
    .instret(ir0),
`endif
    .cause(cause0));
  writeback_stage #(.SQUASH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .u(u1), .uopIn(uop), .trapVector(tv),
    .rfWe(rf_we1), .rfWaddr(rf_wa1), .rfWdata(rf_wd1), .flagsWe(fl_we1), .flagsOut(fo1),
    .redirValid(rv1), .redirPc(rpc1), .flush(fl1), .epc(epc1),
`ifdef WB_RETIRE_CNT_EN
    .instret(ir1),
`endif
    .cause(cause1));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic set_uop(input logic exv, input ex_t ex, input logic nack, input reg_t rd,
                         input val_t val, input logic rdw, input logic fv, input flags_t f, input logic [31:0] pc);
    uop = '{ex: ex, exValid: exv, rd: rd, rdVal: val, rdWrite: rdw, flagsValid: fv, flags: f, memNack: nack, pc: pc};
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    tv = 32'h80;
    u0.valid = 1'b1;
    u1.valid = 1'b1;
    set_uop(0, EX_NONE, 0, 5'd5, 32'h1234, 1, 1, 4'h3, 32'h0);
    check("rst_rfwe", rf_we0, 0);
    check("rst_flwe", fl_we0, 0);
    tick(); tick();
    check("rst_redir", rv0, 0);
    check("rst_flush", fl0, 0);
    check("rst_rpc", rpc0, 0);
    check("rst_epc", epc0, 0);
    check("rst_cause", cause0, EX_NONE);
    check("stall", u0.stall, 0);
`ifdef WB_RETIRE_CNT_EN
    check("rst_instret", ir0, 0);
`endif
    rst = 1'b0;
    set_uop(0, EX_NONE, 0, 5'd5, 32'h1234, 1, 1, 4'hA, 32'h10);
    check("alu_rfwe", rf_we0, 1);
    check("alu_waddr", rf_wa0, 5);
    check("alu_wdata", rf_wd0, 32'h1234);
    check("alu_flwe", fl_we0, 1);
    check("alu_flags", fo0, 4'hA);
    tick();
`ifdef WB_RETIRE_CNT_EN
    check("alu_instret", ir0, 1);
`endif
    set_uop(0, EX_NONE, 0, 5'd0, 32'h55, 1, 0, 4'h0, 32'h14);
    check("rd0_rfwe", rf_we0, 0);
    check("rd0_flwe", fl_we0, 0);
    tick();
`ifdef WB_RETIRE_CNT_EN
    check("rd0_instret", ir0, 2);
`endif
    set_uop(1, EX_MEM_ALIGN, 0, 5'd3, 32'h9, 1, 1, 4'h1, 32'h100);
    check("exc_rfwe", rf_we0, 0);
    check("exc_flwe", fl_we0, 0);
    tick();
    check("exc_redir", rv0, 1);
    check("exc_flush", fl0, 1);
    check("exc_rpc", rpc0, 32'h80);
    check("exc_epc", epc0, 32'h100);
    check("exc_cause", cause0, EX_MEM_ALIGN);
    check("exc_redir_n1", rv1, 1);
    set_uop(0, EX_NONE, 0, 5'd7, 32'h77, 1, 1, 4'h2, 32'h104);
    check("sq1_rfwe", rf_we0, 0);
    check("sq1_rfwe_n1", rf_we1, 0);
    tick();
    check("pulse_end", rv0, 0);
    check("flush_end", fl0, 0);
    check("sq2_rfwe", rf_we0, 0);
    check("sq2_flwe", fl_we0, 0);
    check("run_rfwe_n1", rf_we1, 1);
    tick();
    u1.valid = 1'b0;
    set_uop(1, EX_ILLEGAL, 0, 5'd7, 32'h77, 1, 1, 4'h2, 32'h200);
    check("sq3_rfwe", rf_we0, 0);
    tick();
    check("b2b_redir", rv0, 0);
    check("b2b_epc", epc0, 32'h100);
    check("b2b_cause", cause0, EX_MEM_ALIGN);
    u1.valid = 1'b1;
    set_uop(0, EX_NONE, 0, 5'd7, 32'h78, 1, 0, 4'h0, 32'h108);
    check("post_rfwe", rf_we0, 1);
    check("post_wdata", rf_wd0, 32'h78);
    tick();
`ifdef WB_RETIRE_CNT_EN
    check("post_instret", ir0, 3);
`endif
    set_uop(0, EX_NONE, 1, 5'd8, 32'h88, 1, 1, 4'h4, 32'h2C);
    check("nack_rfwe", rf_we0, 0);
    check("nack_flwe", fl_we0, 0);
    tick();
    check("nack_redir", rv0, 1);
    check("nack_rpc", rpc0, 32'h2C);
    check("nack_epc", epc0, 32'h100);
    check("nack_cause", cause0, EX_MEM_ALIGN);
    check("nack_rpc_n1", rpc1, 32'h2C);
    set_uop(0, EX_NONE, 0, 5'd9, 32'h99, 1, 0, 4'h0, 32'h30);
    check("nsq1_rfwe", rf_we0, 0);
    check("nsq1_rfwe_n1", rf_we1, 0);
    tick();
    check("nsq2_rfwe", rf_we0, 0);
    check("n1_resume_rfwe", rf_we1, 1);
    tick();
    check("nsq3_rfwe", rf_we0, 0);
    tick();
    check("nrun_rfwe", rf_we0, 1);
    tick();
`ifdef WB_RETIRE_CNT_EN
    check("nrun_instret", ir0, 4);
`endif
    tv = 32'h90;
    set_uop(1, EX_MEM_FAULT, 1, 5'd4, 32'h44, 1, 1, 4'h5, 32'h300);
    check("both_rfwe", rf_we0, 0);
    tick();
    check("both_redir", rv0, 1);
    check("both_rpc", rpc0, 32'h90);
    check("both_epc", epc0, 32'h300);
    check("both_cause", cause0, EX_MEM_FAULT);
    rst = 1'b1;
    set_uop(0, EX_NONE, 0, 5'd6, 32'h66, 1, 1, 4'h6, 32'h304);
    check("rsq_rfwe", rf_we0, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rsq_flush", fl0, 0);
    check("rsq_redir", rv0, 0);
    check("rsq_epc", epc0, 0);
    check("rsq_rfwe_run", rf_we0, 1);
    check("rsq_waddr", rf_wa0, 6);
    tick();
`ifdef WB_RETIRE_CNT_EN
    check("rsq_instret", ir0, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage; consumes `Uop::memory_t` from the memory stage and commits results to the register file and flags. It resolves exceptions and data-cache NACKs by flushing the pipeline and redirecting fetch. While a flush drains, it squashes wrong-path uops for a fixed window.

## Interface
Parameters:
- `SQUASH_CYCLES`, default 3: cycles incoming uops are ignored after a redirect, counting the redirect cycle; legal range 1–15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `u`  pipeline_if.Upstream  —  `u.valid` in; `u.stall` out, tied 0.
- `uopIn`  in  `Uop::memory_t`  uop from the memory stage. Fields used: `ex`, `exValid`, `rd`, `rdVal`, `rdWrite`, `flagsValid`, `flags`, `memNack`, `pc`.
- `trapVector`  in  32  trap handler address.
- `rfWe`  out  1  register file write enable.
- `rfWaddr`  out  `Uop::reg_t`  write register.
- `rfWdata`  out  `Uop::val_t`  write data.
- `flagsWe`  out  1  flags write enable.
- `flagsOut`  out  `Uop::flags_t`  flags value.
- `redirValid`  out  1  fetch redirect, registered one-cycle pulse.
- `redirPc`  out  32  redirect target.
- `flush`  out  1  kills all upstream stages; coincident with `redirValid`.
- `epc`  out  32  PC of the last trapping uop.
- `cause`  out  `Uop::ex_t`  exception code of the last trap.
- `instret`  out  64  retired-uop count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
- FSM states: `RUN` and `SQUASH`. Reset enters `RUN`.
- A uop is **live** when `u.valid && state==RUN && !rst`. Classify each live uop, highest priority first:
  - **Exception** (`exValid`):
    - No RF or flags write.
    - Next edge: `epc<=pc`, `cause<=ex`, `redirPc<=trapVector`, `redirValid<=1`, `flush<=1`, state→`SQUASH`.
  - **NACK** (`memNack`, `exValid`=0):
    - No writes.
    - Next edge: `redirPc<=pc` (replay), `redirValid<=1`, `flush<=1`, state→`SQUASH`.
    - `epc` and `cause` are unchanged.
  - **Commit**:
    - `rfWe = rdWrite && rd!=0`, `rfWaddr=rd`, `rfWdata=rdVal`.
    - `flagsWe=flagsValid`, `flagsOut=flags`.
    - Counts as retired.
- `SQUASH`:
  - A counter loads `SQUASH_CYCLES-1` on entry and decrements each cycle. State returns to `RUN` on the edge where the counter is 0.
  - No writes occur while in `SQUASH`.
  - Incoming uops are dropped silently; no new redirect can be raised.
- `exValid` and `memNack` both set: treated as an exception, because the cache was never accessed.
- `rd==0` with `rdWrite` set: the write is suppressed, but the uop still retires.

## Timing
- Commit is combinational from `uopIn`; the register file captures at the next edge (0-cycle stage latency).
- `redirValid`/`flush` rise at the edge after the faulting uop and stay high for exactly 1 cycle.
- A uop arriving in that cycle is already squashed.
- Reset values:
  - `redirValid`=0, `flush`=0, `redirPc`=0, `epc`=0, `cause`=0, `instret`=0.
  - Counter=0, state=`RUN`.
  - `rfWe`/`flagsWe` are forced 0 while `rst`.
- Reset during `SQUASH`: state→`RUN` at that edge and any pending pulse is cleared.
- `SQUASH_CYCLES=1`: only the redirect cycle is squashed; `RUN` resumes the next cycle.
- A back-to-back fault behind a fault is squashed, not reported.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - The `instret` port exists.
  - A 64-bit counter increments by 1 per committed uop and wraps from 2^64−1 to 0.
- `WB_RETIRE_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- The `Uop` package gains fields `memory_t.pc` (32) and `memory_t.rdWrite` (1).
- The `Uop` package gains `wb_state_t` {`WB_RUN`, `WB_SQUASH`}.
- `ex_t` codes (including `EX_MEM_ALIGN`) stay in `Uop`.
- Sub-module `squash_timer`: a loadable down-counter with a `done` output, parameterised by width.
- The commit/classify logic stays inline.

## Test plan
- Commit ALU uop `rd=5`, `rdVal=0x1234`, `rdWrite=1`, `flagsValid=1` → same cycle `rfWe=1`, `rfWaddr=5`, `rfWdata=0x1234`, `flagsWe=1`; `instret` 0→1.
- Uop `rd=0`, `rdWrite=1` → `rfWe=0`, `instret` increments.
- `exValid=1`, `ex=EX_MEM_ALIGN`, `pc=0x100`, `trapVector=0x80` → next cycle `redirValid=flush=1`, `redirPc=0x80`, `epc=0x100`, `cause=EX_MEM_ALIGN`. The 3 following valid uops produce no writes; the 4th commits.
- `memNack=1`, `pc=0x2C` → `redirPc=0x2C`, `epc` unchanged, no `rfWe`. With `SQUASH_CYCLES=1`, the uop on the cycle after the pulse commits.
- `exValid=1` and `memNack=1` together, `trapVector=0x80` → handled as an exception: `redirPc=0x80`.
- `rst` asserted one cycle into `SQUASH` → next cycle state `RUN`, `flush=0`, a valid uop commits.
